// File: rtl/bdd_walk_engine.sv
// BDD walk engine: evaluates OUT_BITS decision diagrams, one node per cycle, over a latched input vector.
// Define BDD_STEP_LIMIT_EN to add a per-bit step counter that aborts walks through cyclic tables.
module bdd_walk_engine #(
  parameter int IN_W       = 1894,
  parameter int NODE_DEPTH = 256,
  parameter int OUT_BITS   = 4,
  parameter int PTR_W      = $clog2(NODE_DEPTH),
  parameter int VAR_W      = $clog2(IN_W),
  parameter int SEL_W      = (OUT_BITS > 1) ? $clog2(OUT_BITS) : 1
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                cfg_we,
  input  logic [PTR_W-1:0]    cfg_addr,
  input  logic [VAR_W-1:0]    cfg_var,
  input  logic [PTR_W-1:0]    cfg_lo,
  input  logic [PTR_W-1:0]    cfg_hi,
  input  logic                root_we,
  input  logic [SEL_W-1:0]    root_sel,
  input  logic [PTR_W-1:0]    root_ptr,
  input  logic                in_valid,
  output logic                in_ready,
  input  logic [IN_W-1:0]     in_vec,
  output logic                out_valid,
  input  logic                out_ready,
  output logic [OUT_BITS-1:0] out_vec,
  output logic                busy,
  output logic                err
);
  localparam int NODE_W = VAR_W + 2 * PTR_W;

  typedef enum logic [1:0] {IDLE, WALK, DONE} state_t;

  state_t              state_q, state_d;
  logic [PTR_W-1:0]    ptr_q, ptr_d;
  logic [SEL_W-1:0]    k_q, k_d;
  logic [IN_W-1:0]     vec_q, vec_d;
  logic [OUT_BITS-1:0] out_vec_q, out_vec_d;
  logic [PTR_W-1:0]    root_q [OUT_BITS];
  logic [PTR_W-1:0]    root_d [OUT_BITS];
  logic                prime_q, prime_d;
  logic                in_ready_q, in_ready_d;
  logic                busy_q, busy_d;
  logic                out_valid_q, out_valid_d;

  logic [NODE_W-1:0]   node_mem [NODE_DEPTH];
  logic [NODE_W-1:0]   node_q;
  logic [VAR_W-1:0]    node_var;
  logic [PTR_W-1:0]    node_lo, node_hi;
  logic                var_bit, node_we, is_node, step_abort;
  logic                term_hit, term_val;

  assign {node_var, node_lo, node_hi} = node_q;
  assign var_bit = (32'(node_var) < IN_W) ? vec_q[node_var] : 1'b0;
  assign node_we = cfg_we && !busy_q && (cfg_addr > PTR_W'(1));
  assign is_node = (ptr_q > PTR_W'(1));

`ifdef BDD_STEP_LIMIT_EN
  logic [PTR_W-1:0] steps_q, steps_d;
  logic             err_q, err_d;
  assign step_abort = (steps_q == PTR_W'(NODE_DEPTH - 2));
  assign err        = err_q;
`else
  assign step_abort = 1'b0;
  assign err        = 1'b0;
`endif

  // Read address is the next pointer so node_q always describes ptr_q; the first
  // WALK cycle (prime) refetches so a same-cycle table write is seen.
  always_ff @(posedge clk) begin
    if (node_we) node_mem[cfg_addr] <= {cfg_var, cfg_lo, cfg_hi};
    node_q <= node_mem[ptr_d];
  end

  always_comb begin
    state_d   = state_q;
    ptr_d     = ptr_q;
    k_d       = k_q;
    vec_d     = vec_q;
    out_vec_d = out_vec_q;
    root_d    = root_q;
    prime_d   = 1'b0;
    term_hit  = 1'b0;
    term_val  = 1'b0;
`ifdef BDD_STEP_LIMIT_EN
    steps_d   = steps_q;
    err_d     = err_q;
`endif
    case (state_q)
      IDLE: begin
        if (root_we && (32'(root_sel) < OUT_BITS)) root_d[root_sel] = root_ptr;
        if (in_valid) begin
          vec_d   = in_vec;
          k_d     = '0;
          ptr_d   = root_d[0];
          prime_d = 1'b1;
          state_d = WALK;
`ifdef BDD_STEP_LIMIT_EN
          steps_d = '0;
          err_d   = 1'b0;
`endif
        end
      end
      WALK: begin
        if (prime_q) begin
          ptr_d = ptr_q;
        end else if (is_node && !step_abort) begin
          ptr_d = var_bit ? node_hi : node_lo;
`ifdef BDD_STEP_LIMIT_EN
          steps_d = steps_q + 1'b1;
`endif
        end else begin
          term_hit = 1'b1;
          term_val = is_node ? 1'b0 : ptr_q[0];
`ifdef BDD_STEP_LIMIT_EN
          err_d = err_q | is_node;
`endif
        end
        if (term_hit) begin
          out_vec_d[k_q] = term_val;
`ifdef BDD_STEP_LIMIT_EN
          steps_d = '0;
`endif
          if (32'(k_q) == OUT_BITS - 1) begin
            state_d = DONE;
          end else begin
            k_d   = k_q + 1'b1;
            ptr_d = root_q[k_d];
          end
        end
      end
      DONE: if (out_ready) state_d = IDLE;
      default: state_d = IDLE;
    endcase
    in_ready_d  = (state_d == IDLE);
    busy_d      = (state_d != IDLE);
    out_valid_d = (state_d == DONE);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= IDLE;
      ptr_q       <= '0;
      k_q         <= '0;
      vec_q       <= '0;
      out_vec_q   <= '0;
      root_q      <= '{default: '0};
      prime_q     <= 1'b0;
      in_ready_q  <= 1'b1;
      busy_q      <= 1'b0;
      out_valid_q <= 1'b0;
`ifdef BDD_STEP_LIMIT_EN
      steps_q     <= '0;
      err_q       <= 1'b0;
`endif
    end else begin
      state_q     <= state_d;
      ptr_q       <= ptr_d;
      k_q         <= k_d;
      vec_q       <= vec_d;
      out_vec_q   <= out_vec_d;
      root_q      <= root_d;
      prime_q     <= prime_d;
      in_ready_q  <= in_ready_d;
      busy_q      <= busy_d;
      out_valid_q <= out_valid_d;
`ifdef BDD_STEP_LIMIT_EN
      steps_q     <= steps_d;
      err_q       <= err_d;
`endif
    end
  end

  assign in_ready  = in_ready_q;
  assign busy      = busy_q;
  assign out_valid = out_valid_q;
  assign out_vec   = out_vec_q;
endmodule

// File: tb/tb_bdd_walk_engine.sv
// Self-checking bench for bdd_walk_engine: directed scenarios plus random acyclic tables
// checked against a node-walking reference model.
module tb_bdd_walk_engine;
  localparam int IN_W = 8;
  localparam int ND   = 8;
  localparam int OB   = 2;

  logic       clk = 1'b0;
  logic       rst;
  logic       cfg_we;
  logic [2:0] cfg_addr, cfg_var, cfg_lo, cfg_hi;
  logic       root_we;
  logic [0:0] root_sel;
  logic [2:0] root_ptr;
  logic       in_valid, in_ready;
  logic [7:0] in_vec;
  logic       out_valid, out_ready;
  logic [1:0] out_vec;
  logic       busy, err;

  always #5 clk = ~clk;

  bdd_walk_engine #(.IN_W(IN_W), .NODE_DEPTH(ND), .OUT_BITS(OB)) dut (
    .clk(clk), .rst(rst),
    .cfg_we(cfg_we), .cfg_addr(cfg_addr), .cfg_var(cfg_var), .cfg_lo(cfg_lo), .cfg_hi(cfg_hi),
    .root_we(root_we), .root_sel(root_sel), .root_ptr(root_ptr),
    .in_valid(in_valid), .in_ready(in_ready), .in_vec(in_vec),
    .out_valid(out_valid), .out_ready(out_ready), .out_vec(out_vec),
    .busy(busy), .err(err)
  );

  int n_vec = 0;
  int n_mis = 0;
  int n_txn = 0;
  int m_var [ND];
  int m_lo  [ND];
  int m_hi  [ND];
  int m_root[OB];

  // Reference: walk each root through the table; latency 1 + sum(nodes visited + 1).
  function automatic void model_run(input logic [7:0] v, output logic [1:0] o,
                                    output int lat, output bit e);
    int p, s;
    bit ab;
    o = '0; lat = 1; e = 1'b0;
    for (int b = 0; b < OB; b++) begin
      p = m_root[b]; s = 0; ab = 1'b0;
      while (p > 1 && !ab && s < 64) begin
`ifdef BDD_STEP_LIMIT_EN
        if (s == ND - 2) begin ab = 1'b1; e = 1'b1; end else
`endif
        begin
          p = v[m_var[p]] ? m_hi[p] : m_lo[p];
          s++;
        end
      end
      o[b] = ab ? 1'b0 : p[0];
      lat += s + 1;
    end
  endfunction

  function automatic int pick_child(input int a);
    if ($urandom_range(0, 2) == 0 || a >= ND - 1) return int'($urandom_range(0, 1));
    return int'($urandom_range(a + 1, ND - 1));
  endfunction

  task automatic do_cfg(input int a, input int v, input int lo, input int hi);
    @(negedge clk);
    cfg_we = 1'b1; cfg_addr = 3'(a); cfg_var = 3'(v); cfg_lo = 3'(lo); cfg_hi = 3'(hi);
    @(negedge clk);
    cfg_we = 1'b0;
    if (a > 1) begin m_var[a] = v; m_lo[a] = lo; m_hi[a] = hi; end
  endtask

  task automatic do_root(input int sel, input int p);
    @(negedge clk);
    root_we = 1'b1; root_sel = 1'(sel); root_ptr = 3'(p);
    @(negedge clk);
    root_we = 1'b0;
    m_root[sel] = p;
  endtask

  task automatic run_vec(input logic [7:0] v, input int hold, input bit wcfg,
                         input int a, input int vr, input int lo, input int hi);
    logic [1:0] eo;
    int elat, cyc;
    bit ee;
    @(negedge clk);
    in_valid = 1'b1; in_vec = v;
    if (wcfg) begin
      cfg_we = 1'b1; cfg_addr = 3'(a); cfg_var = 3'(vr); cfg_lo = 3'(lo); cfg_hi = 3'(hi);
      if (a > 1) begin m_var[a] = vr; m_lo[a] = lo; m_hi[a] = hi; end
    end
    model_run(v, eo, elat, ee);
    n_vec++;
    if (in_ready !== 1'b1) begin
      n_mis++; $display("FAIL in_ready_idle: got %b want 1", in_ready);
    end
    @(posedge clk); #1;
    in_valid = 1'b0; cfg_we = 1'b0; cyc = 0;
    while (out_valid !== 1'b1 && cyc < 200) begin @(posedge clk); #1; cyc++; end
    n_vec++;
    if (cyc != elat) begin
      n_mis++; $display("FAIL latency vec=%h: got %0d want %0d", v, cyc, elat);
    end
    n_vec++;
    if (out_vec !== eo || err !== ee || in_ready !== 1'b0 || busy !== 1'b1) begin
      n_mis++;
      $display("FAIL result vec=%h: got out=%b err=%b rdy=%b busy=%b want out=%b err=%b rdy=0 busy=1",
               v, out_vec, err, in_ready, busy, eo, ee);
    end
    for (int i = 0; i < hold; i++) begin
      @(posedge clk); #1;
      n_vec++;
      if (out_valid !== 1'b1 || out_vec !== eo || in_ready !== 1'b0) begin
        n_mis++;
        $display("FAIL hold cyc %0d: got vld=%b out=%b rdy=%b want vld=1 out=%b rdy=0",
                 i, out_valid, out_vec, in_ready, eo);
      end
    end
    out_ready = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b0;
    n_vec++;
    if (in_ready !== 1'b1 || out_valid !== 1'b0 || busy !== 1'b0 || out_vec !== eo) begin
      n_mis++;
      $display("FAIL release: got rdy=%b vld=%b busy=%b out=%b want rdy=1 vld=0 busy=0 out=%b",
               in_ready, out_valid, busy, out_vec, eo);
    end
    n_txn++;
    $display("txn %0d vec=%h out=%b exp=%b lat=%0d exp_lat=%0d err=%b", n_txn, v, out_vec, eo, cyc, elat, err);
  endtask

  task automatic test_reset();
    rst = 1'b1;
    repeat (3) @(posedge clk);
    @(negedge clk);
    n_vec++;
    if (in_ready !== 1'b1 || out_valid !== 1'b0 || busy !== 1'b0) begin
      n_mis++; $display("FAIL reset_hs: got rdy=%b vld=%b busy=%b want 1 0 0", in_ready, out_valid, busy);
    end
    n_vec++;
    if (out_vec !== 2'b00 || err !== 1'b0) begin
      n_mis++; $display("FAIL reset_out: got out=%b err=%b want 00 0", out_vec, err);
    end
    rst = 1'b0;
    @(negedge clk);
    n_vec++;
    if (in_ready !== 1'b1 || out_valid !== 1'b0 || out_vec !== 2'b00) begin
      n_mis++; $display("FAIL post_reset: got rdy=%b vld=%b out=%b want 1 0 00", in_ready, out_valid, out_vec);
    end
    for (int i = 0; i < OB; i++) m_root[i] = 0;
  endtask

  task automatic test_directed();
    do_cfg(2, 3, 0, 1);
    do_cfg(3, 5, 1, 2);
    do_root(0, 2);
    do_root(1, 3);
    run_vec(8'h28, 0, 1'b0, 0, 0, 0, 0);
    run_vec(8'h20, 0, 1'b0, 0, 0, 0, 0);
    run_vec(8'h00, 0, 1'b0, 0, 0, 0, 0);
  endtask

  task automatic test_busy_write();
    logic [1:0] eo;
    int elat, cyc;
    bit ee;
    model_run(8'h28, eo, elat, ee);
    @(negedge clk);
    in_valid = 1'b1; in_vec = 8'h28;
    @(posedge clk); #1;
    in_valid = 1'b0; cyc = 0;
    cfg_we = 1'b1; cfg_addr = 3'd2; cfg_var = 3'd0; cfg_lo = 3'd0; cfg_hi = 3'd0;
    root_we = 1'b1; root_sel = 1'b0; root_ptr = 3'd0;
    while (out_valid !== 1'b1 && cyc < 200) begin @(posedge clk); #1; cyc++; end
    n_vec++;
    if (out_vec !== eo || cyc != elat) begin
      n_mis++; $display("FAIL busy_write: got out=%b lat=%0d want out=%b lat=%0d", out_vec, cyc, eo, elat);
    end
    out_ready = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b0; cfg_we = 1'b0; root_we = 1'b0;
    n_vec++;
    if (in_ready !== 1'b1) begin
      n_mis++; $display("FAIL busy_write_release: got rdy=%b want 1", in_ready);
    end
    n_txn++;
    $display("txn %0d vec=28 out=%b exp=%b (writes while busy)", n_txn, out_vec, eo);
    run_vec(8'h28, 0, 1'b0, 0, 0, 0, 0);
  endtask

  task automatic test_same_cycle();
    run_vec(8'h28, 1, 1'b1, 2, 3, 1, 0);
    run_vec(8'h00, 0, 1'b1, 2, 3, 0, 1);
    run_vec(8'h28, 0, 1'b1, 1, 0, 0, 0);
  endtask

  task automatic test_reset_midwalk();
    bit stale;
    @(negedge clk);
    in_valid = 1'b1; in_vec = 8'h28;
    @(posedge clk); #1;
    in_valid = 1'b0;
    repeat (2) begin @(posedge clk); #1; end
    rst = 1'b1;
    #1;
    n_vec++;
    if (out_valid !== 1'b0 || in_ready !== 1'b1 || out_vec !== 2'b00 || busy !== 1'b0) begin
      n_mis++;
      $display("FAIL reset_midwalk: got vld=%b rdy=%b out=%b busy=%b want 0 1 00 0", out_valid, in_ready, out_vec, busy);
    end
    @(negedge clk);
    rst = 1'b0;
    for (int i = 0; i < OB; i++) m_root[i] = 0;
    stale = 1'b0;
    repeat (10) begin @(posedge clk); #1; if (out_valid !== 1'b0) stale = 1'b1; end
    n_vec++;
    if (stale) begin
      n_mis++; $display("FAIL stale_valid: got out_valid=1 after reset want 0");
    end
    n_txn++;
    $display("txn %0d vec=28 aborted by reset", n_txn);
    run_vec(8'h28, 0, 1'b0, 0, 0, 0, 0);
  endtask

  task automatic test_random();
    int a;
    for (int n = 2; n < ND; n++) do_cfg(n, int'($urandom_range(0, 7)), pick_child(n), pick_child(n));
    for (int s = 0; s < OB; s++) do_root(s, int'($urandom_range(0, ND - 1)));
    for (int t = 0; t < 30; t++) begin
      case ($urandom_range(0, 9))
        0: do_root(int'($urandom_range(0, OB - 1)), int'($urandom_range(0, ND - 1)));
        1: begin
          a = int'($urandom_range(0, ND - 1));
          do_cfg(a, int'($urandom_range(0, 7)), pick_child(a), pick_child(a));
        end
        default: ;
      endcase
      a = int'($urandom_range(0, ND - 1));
      run_vec(8'($urandom), int'($urandom_range(0, 3)), ($urandom_range(0, 3) == 0),
              a, int'($urandom_range(0, 7)), pick_child(a), pick_child(a));
    end
  endtask

`ifdef BDD_STEP_LIMIT_EN
  task automatic test_step_limit();
    do_cfg(4, 0, 4, 4);
    do_root(0, 4);
    run_vec(8'($urandom), 0, 1'b0, 0, 0, 0, 0);
    do_root(0, 0);
    run_vec(8'($urandom), 0, 1'b0, 0, 0, 0, 0);
  endtask
`endif

  initial begin
    rst = 1'b1; cfg_we = 1'b0; cfg_addr = '0; cfg_var = '0; cfg_lo = '0; cfg_hi = '0;
    root_we = 1'b0; root_sel = '0; root_ptr = '0;
    in_valid = 1'b0; in_vec = '0; out_ready = 1'b0;
    test_reset();
    run_vec(8'hFF, 0, 1'b0, 0, 0, 0, 0);
    test_directed();
    run_vec(8'h28, 5, 1'b0, 0, 0, 0, 0);
    test_busy_write();
    test_same_cycle();
    test_reset_midwalk();
    test_random();
`ifdef BDD_STEP_LIMIT_EN
    test_step_limit();
`endif
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_mis);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end
endmodule

// File: doc/bdd_walk_engine.md
BDD_WALK_ENGINE -- requirements
Module: bdd_walk_engine

Interface
REQ-001 Parameters SHALL be: IN_W, default 1894, width of the input vector; NODE_DEPTH, default 256, node-table entries; OUT_BITS, default 4, number of output bits (roots); PTR_W = clog2(NODE_DEPTH); VAR_W = clog2(IN_W).
REQ-002 Ports SHALL be:
- clk  in  1  clock; one clock, all state on rising edge.
- rst  in  1  asynchronous, active-high reset.
- cfg_we  in  1  node-table write strobe.
- cfg_addr  in  PTR_W  node index.
- cfg_var  in  VAR_W  decision variable.
- cfg_lo  in  PTR_W  child when the variable is 0.
- cfg_hi  in  PTR_W  child when the variable is 1.
- root_we  in  1  root write strobe.
- root_sel  in  clog2(OUT_BITS)  output bit selected.
- root_ptr  in  PTR_W  root pointer.
- in_valid  in  1  input vector offered.
- in_ready  out  1  engine can accept a vector.
- in_vec  in  IN_W  input vector.
- out_valid  out  1  result available.
- out_ready  in  1  result consumed.
- out_vec  out  OUT_BITS  result bits.
- busy  out  1  high in WALK or DONE.
- err  out  1  step-limit abort flag.

Function
REQ-003 Pointer values SHALL be decoded as follows: 0 is terminal FALSE, 1 is terminal TRUE, and values 2..NODE_DEPTH-1 are decision nodes.
REQ-004 The FSM SHALL have three states: IDLE, WALK and DONE. in_ready SHALL be 1 only in IDLE.
REQ-005 When in_valid and in_ready are both high, the engine SHALL latch in_vec, set the bit index k to 0, set ptr to root[0], and enter WALK on the next cycle.
REQ-006 In WALK, each cycle the engine SHALL evaluate ptr:
- Non-terminal: ptr <= (latched_vec[node[ptr].var] ? node[ptr].hi : node[ptr].lo).
- Terminal: out_vec[k] <= ptr[0]; then either k <= k+1 and ptr <= root[k+1], or, if k = OUT_BITS-1, go to DONE.
REQ-007 Latency from acceptance to out_valid SHALL be 1 + sum over k of (decision nodes visited for bit k + 1) cycles.
REQ-008 In DONE, out_valid SHALL be 1 and out_vec SHALL be stable. On out_valid & out_ready the engine SHALL return to IDLE on the next cycle.
REQ-009 A var index >= IN_W SHALL read the variable as 0.
REQ-010 cfg_we and root_we SHALL be ignored while busy = 1. cfg_we to address 0 or 1 SHALL be ignored.
REQ-011 A table write and an input acceptance in the same IDLE cycle SHALL both occur. The walk SHALL use the updated table.
REQ-012 out_vec SHALL hold its last value in IDLE.

Reset
REQ-013 rst SHALL immediately force IDLE, with in_ready=1, out_valid=0, out_vec=0, err=0, busy=0, k=0, and all roots=0. A walk in progress SHALL be discarded with no output.
REQ-014 The node table SHALL NOT be reset. Because every root resets to terminal FALSE, an unprogrammed engine returns all zeros.

Configuration
REQ-015 With macro BDD_STEP_LIMIT_EN defined:
- A per-bit step counter SHALL count decision nodes visited.
- Reaching NODE_DEPTH-2 steps on a non-terminal (a cyclic table) SHALL force out_vec[k]=0, set err=1, and advance to the next bit.
- err SHALL clear on the next acceptance or on reset.
REQ-016 Without BDD_STEP_LIMIT_EN, no counter SHALL exist and err SHALL be constant 0. A cyclic table then hangs the engine until rst.

Verification (bench: IN_W=8, NODE_DEPTH=8, OUT_BITS=2)
REQ-017 Reset, then offer in_vec=8'hFF with no programming -> in_ready=1; out_valid asserts 3 cycles after acceptance with out_vec=2'b00.
REQ-018 Program the table and roots:
- node2 = {var3, lo 0, hi 1}; node3 = {var5, lo 1, hi 2}.
- root0 = 2, root1 = 3.
- in_vec=8'h28 -> out_vec=2'b11 after 6 cycles.
- in_vec=8'h20 -> out_vec=2'b00.
- in_vec=8'h00 -> out_vec=2'b10.
REQ-019 Hold out_ready=0 for 5 cycles in DONE -> out_valid and out_vec stay stable and in_ready=0. Raising out_ready -> in_ready=1 next cycle.
REQ-020 Assert cfg_we to node2 while busy -> table unchanged; a repeat of in_vec=8'h28 still gives 2'b11.
REQ-021 Assert rst two cycles into a walk -> out_valid=0, in_ready=1, out_vec=0 immediately; no stale out_valid afterwards.
REQ-022 With BDD_STEP_LIMIT_EN, program node4 = {var0, lo 4, hi 4}, root0 = 4 -> after 6 steps, err=1, out_vec[0]=0, and bit 1 completes normally.
